// File: rtl/wb_burst_ram_slave_if.sv
// Wishbone B3 bus bundle between a master and the burst RAM slave.
// Data names are from the bus point of view: wdat master->slave, rdat slave->master.
interface wb_burst_ram_slave_if;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] rdat;
    logic        ack;
    logic        err;

    modport master (
        output adr, wdat, sel, we, cyc, stb, cti, bte,
        input  rdat, ack, err
    );

    modport slave (
        input  adr, wdat, sel, we, cyc, stb, cti, bte,
        output rdat, ack, err
    );
endinterface

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B3 registered-feedback RAM slave with CTI/BTE bursts,
// programmable first-beat wait states and out-of-range error response.
module wb_burst_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH       = 4096,
    parameter int          WAIT_STATES = 0,
    parameter string       MEMFILE     = ""
) (
    input logic                 wb_clk,
    input logic                 wb_rst,
    wb_burst_ram_slave_if.slave wb
);
    localparam int          AW   = $clog2(DEPTH);
    localparam logic [32:0] SPAN = 33'(DEPTH) << 2;
    localparam logic [3:0]  WS   = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t      state, state_n;
    logic        ack, ack_n;
    logic        err, err_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] cur, cur_n;
    logic [2:0]  cti_q, cti_n;
    logic [1:0]  bte_q, bte_n;
    logic [31:0] tgt;
    logic        issue;
    logic        req;
    logic        wr_en;
    logic [31:0] rdat;
    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return {1'b0, off} < SPAN;
    endfunction

    function automatic logic [AW-1:0] idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return AW'(off >> 2);
    endfunction

    function automatic logic is_burst(input logic [2:0] c);
        return (c == 3'b001) || (c == 3'b010);
    endfunction

    // Wrap modes only touch the low word-index bits; constant bursts hold.
    function automatic logic [31:0] step(input logic [31:0] a);
        logic [31:0] n;
        n = a;
        if (cti_q == 3'b010) begin
            case (bte_q)
                2'b00:   n      = a + 32'd4;
                2'b01:   n[3:2] = a[3:2] + 2'd1;
                2'b10:   n[4:2] = a[4:2] + 3'd1;
                default: n[5:2] = a[5:2] + 4'd1;
            endcase
        end
        return n;
    endfunction

    assign req   = wb.cyc & wb.stb;
    assign wr_en = ack & req & wb.we;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cur_n   = cur;
        cti_n   = cti_q;
        bte_n   = bte_q;
        tgt     = cur;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                // A request still held during its own ack is not re-accepted.
                if (req && !ack && !err) begin
                    cur_n = wb.adr;
                    cti_n = wb.cti;
                    bte_n = wb.bte;
                    tgt   = wb.adr;
                    if (WS == 4'd0) begin
                        issue = 1'b1;
                        if (is_burst(wb.cti) && in_range(wb.adr))
                            state_n = BURST;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WS;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_n = IDLE;
                    cnt_n   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    cnt_n   = 4'd0;
                    issue   = 1'b1;
                    state_n = (is_burst(cti_q) && in_range(cur)) ? BURST : IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            BURST: begin
                if (!req || wb.cti == 3'b111) begin
                    state_n = IDLE;
                end else begin
                    tgt   = step(cur);
                    cur_n = tgt;
                    issue = 1'b1;
                    if (!in_range(tgt)) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        ack_n = issue & in_range(tgt);
        err_n = issue & ~in_range(tgt);
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state <= IDLE;
            ack   <= 1'b0;
            err   <= 1'b0;
            cnt   <= 4'd0;
            cur   <= '0;
            cti_q <= 3'b000;
            bte_q <= 2'b00;
        end else begin
            state <= state_n;
            ack   <= ack_n;
            err   <= err_n;
            cnt   <= cnt_n;
            cur   <= cur_n;
            cti_q <= cti_n;
            bte_q <= bte_n;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst)     rdat <= '0;
        else if (ack_n) rdat <= mem[idx(tgt)];
    end

    // The beat commits on the edge that completes its ack.
    always_ff @(posedge wb_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wb.sel[b]) mem[idx(cur)][8*b +: 8] <= wb.wdat[8*b +: 8];
            end
        end
    end

    assign wb.ack  = ack;
    assign wb.err  = err;
    assign wb.rdat = rdat;
endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed bench for wb_burst_ram_slave: classic table plus burst,
// error, abort, reset and wait-state sequences on two instances.
module tb_wb_burst_ram_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        use3 = 1'b0;
    logic [31:0] adr, wdat;
    logic [3:0]  sel;
    logic        we, cyc, stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack_s, err_s;
    logic [31:0] rdat_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_burst_ram_slave_if b0 ();
    wb_burst_ram_slave_if b3 ();

    assign b0.adr  = adr;
    assign b0.wdat = wdat;
    assign b0.sel  = sel;
    assign b0.we   = we;
    assign b0.cyc  = cyc & ~use3;
    assign b0.stb  = stb & ~use3;
    assign b0.cti  = cti;
    assign b0.bte  = bte;
    assign b3.adr  = adr;
    assign b3.wdat = wdat;
    assign b3.sel  = sel;
    assign b3.we   = we;
    assign b3.cyc  = cyc & use3;
    assign b3.stb  = stb & use3;
    assign b3.cti  = cti;
    assign b3.bte  = bte;

    assign ack_s  = use3 ? b3.ack  : b0.ack;
    assign err_s  = use3 ? b3.err  : b0.err;
    assign rdat_s = use3 ? b3.rdat : b0.rdat;

    wb_burst_ram_slave #(.WAIT_STATES(0)) dut0 (
        .wb_clk(clk),
        .wb_rst(rst),
        .wb    (b0)
    );

    wb_burst_ram_slave #(.WAIT_STATES(3)) dut3 (
        .wb_clk(clk),
        .wb_rst(rst),
        .wb    (b3)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [3:0]  sel;
        logic        xerr;
        logic        chk;
        logic [31:0] xdat;
    } vec_t;

    localparam int NV = 20;
    vec_t v [NV];

    logic [31:0] wd [16];
    logic [31:0] rd [16];
    int          ackedge [16];
    int          nack;
    int          erredge;
    logic        post_a1, post_e1, post_a2;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input int i, input int nb, input logic [31:0] a,
                         input logic w, input logic [3:0] s,
                         input logic [2:0] ct, input logic [1:0] bt);
        cyc  = 1'b1;
        stb  = 1'b1;
        adr  = a;
        we   = w;
        sel  = s;
        wdat = wd[i];
        bte  = bt;
        cti  = (ct != 3'b000 && i == nb - 1) ? 3'b111 : ct;
    endtask

    // Master model: beat i completes on the edge after its ack is seen.
    task automatic run(input int nb, input logic [31:0] a, input logic w,
                       input logic [3:0] s, input logic [2:0] ct,
                       input logic [1:0] bt, input int abort_at);
        int   done;
        logic pa, pe, fin;
        nack = 0; erredge = 0; done = 0;
        pa = 1'b0; pe = 1'b0; fin = 1'b0;
        for (int i = 0; i < 16; i++) ackedge[i] = 0;
        @(negedge clk);
        drive(0, nb, a, w, s, ct, bt);
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(posedge clk);
            if (pa || pe) begin
                #1;
                if (pe) begin
                    fin = 1'b1;
                end else begin
                    done++;
                    if (done == nb || done == abort_at) fin = 1'b1;
                end
                if (fin) begin
                    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
                end else begin
                    drive(done, nb, a, w, s, ct, bt);
                end
            end
            if (!fin) begin
                @(negedge clk);
                pa = ack_s;
                pe = err_s;
                if (pa && nack < 16) begin
                    rd[nack]      = rdat_s;
                    ackedge[nack] = c;
                    nack++;
                end
                if (pe) erredge = c;
            end
        end
        if (!fin) begin
            tests++;
            fails++;
            $display("FAIL timeout adr %h: no completion within 60 edges", a);
            cyc = 1'b0; stb = 1'b0; we = 1'b0;
        end
        @(negedge clk);
        post_a1 = ack_s;
        post_e1 = err_s;
        @(negedge clk);
        post_a2 = ack_s;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] keep [8];
        cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0;
        sel = 0; cti = 0; bte = 0;
        for (int i = 0; i < 16; i++) wd[i] = '0;

        v[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0};
        v[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF};
        v[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0};
        v[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 1'b0, 1'b0, 32'h0};
        v[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11BB_33DD};
        v[5]  = '{1'b1, 32'h0000_0024, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0};
        v[6]  = '{1'b1, 32'h0000_0026, 32'hCAFE_F00D, 4'h0, 1'b0, 1'b0, 32'h0};
        v[7]  = '{1'b0, 32'h0000_0027, 32'h0,         4'hF, 1'b0, 1'b1, 32'h1234_5678};
        v[8]  = '{1'b0, 32'h0000_4000, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
        v[9]  = '{1'b1, 32'h0000_4000, 32'h5555_5555, 4'hF, 1'b1, 1'b0, 32'h0};
        v[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'hF, 1'b1, 1'b0, 32'h0};
        v[11] = '{1'b1, 32'h0000_3FFC, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, 32'h0};
        v[12] = '{1'b0, 32'h0000_3FFD, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0BAD_F00D};
        v[13] = '{1'b1, 32'h0000_3FF8, 32'h55AA_55AA, 4'hF, 1'b0, 1'b0, 32'h0};
        v[14] = '{1'b1, 32'h0000_0030, 32'h3030_3030, 4'hF, 1'b0, 1'b0, 32'h0};
        v[15] = '{1'b1, 32'h0000_0034, 32'h3434_3434, 4'hF, 1'b0, 1'b0, 32'h0};
        v[16] = '{1'b1, 32'h0000_0038, 32'h3838_3838, 4'hF, 1'b0, 1'b0, 32'h0};
        v[17] = '{1'b1, 32'h0000_003C, 32'h3C3C_3C3C, 4'hF, 1'b0, 1'b0, 32'h0};
        v[18] = '{1'b1, 32'h0000_0044, 32'h4444_4444, 4'hF, 1'b0, 1'b0, 32'h0};
        v[19] = '{1'b1, 32'h0000_0208, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack0",  b0.ack,  0);
        chk("rst_err0",  b0.err,  0);
        chk("rst_dat0",  b0.rdat, 0);
        chk("rst_ack3",  b3.ack,  0);
        chk("rst_dat3",  b3.rdat, 0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            wd[0] = v[i].wdat;
            run(1, v[i].adr, v[i].we, v[i].sel, 3'b000, 2'b00, 0);
            if (v[i].xerr) begin
                chk($sformatf("v%0d_err_edge", i), erredge, 1);
                chk($sformatf("v%0d_nack", i), nack, 0);
            end else begin
                chk($sformatf("v%0d_ack_edge", i), ackedge[0], 1);
                chk($sformatf("v%0d_nack", i), nack, 1);
            end
            chk($sformatf("v%0d_ack_drop", i), post_a1, 0);
            chk($sformatf("v%0d_err_drop", i), post_e1, 0);
            if (v[i].chk) chk($sformatf("v%0d_rdat", i), rd[0], v[i].xdat);
        end

        // Wrap4 incrementing read from 0x38
        run(4, 32'h38, 1'b0, 4'hF, 3'b010, 2'b01, 0);
        chk("wrap4_nack", nack, 4);
        chk("wrap4_d0", rd[0], 32'h3838_3838);
        chk("wrap4_d1", rd[1], 32'h3C3C_3C3C);
        chk("wrap4_d2", rd[2], 32'h3030_3030);
        chk("wrap4_d3", rd[3], 32'h3434_3434);
        chk("wrap4_e0", ackedge[0], 1);
        chk("wrap4_e3", ackedge[3], 4);
        chk("wrap4_drop", post_a1, 0);

        // Constant-address burst write
        wd[0] = 32'hA1A1_A1A1; wd[1] = 32'hA2A2_A2A2; wd[2] = 32'hA3A3_A3A3;
        run(3, 32'h40, 1'b1, 4'hF, 3'b001, 2'b00, 0);
        chk("const_nack", nack, 3);
        run(1, 32'h40, 1'b0, 4'hF, 3'b000, 2'b00, 0);
        chk("const_d40", rd[0], 32'hA3A3_A3A3);
        run(1, 32'h44, 1'b0, 4'hF, 3'b000, 2'b00, 0);
        chk("const_d44", rd[0], 32'h4444_4444);

        // Linear burst running off the top of memory
        run(4, 32'h3FF8, 1'b0, 4'hF, 3'b010, 2'b00, 0);
        chk("oor_nack", nack, 2);
        chk("oor_d0", rd[0], 32'h55AA_55AA);
        chk("oor_d1", rd[1], 32'h0BAD_F00D);
        chk("oor_err_edge", erredge, 3);
        chk("oor_err_drop", post_e1, 0);
        chk("oor_ack_drop", post_a1, 0);

        // Abort an 8-beat write after two beats
        for (int i = 0; i < 8; i++) wd[i] = 32'h2000_0000 + 32'(i);
        keep[0] = wd[0]; keep[1] = wd[1];
        run(8, 32'h200, 1'b1, 4'hF, 3'b010, 2'b00, 2);
        chk("abort_nack", nack, 2);
        chk("abort_drop", post_a2, 0);
        run(1, 32'h200, 1'b0, 4'hF, 3'b000, 2'b00, 0);
        chk("abort_d200", rd[0], keep[0]);
        run(1, 32'h204, 1'b0, 4'hF, 3'b000, 2'b00, 0);
        chk("abort_d204", rd[0], keep[1]);
        run(1, 32'h208, 1'b0, 4'hF, 3'b000, 2'b00, 0);
        chk("abort_d208", rd[0], 32'hFFFF_FFFF);

        // Reset in the middle of a read burst
        @(negedge clk);
        cyc = 1; stb = 1; adr = 32'h30; we = 0; sel = 4'hF;
        cti = 3'b010; bte = 2'b00;
        @(posedge clk);
        @(negedge clk);
        chk("rstb_ack1", ack_s, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstb_ack", ack_s, 0);
        chk("rstb_dat", rdat_s, 0);
        @(negedge clk);
        rst = 1'b0; cyc = 0; stb = 0; cti = 3'b000;
        run(1, 32'h30, 1'b0, 4'hF, 3'b000, 2'b00, 0);
        chk("rstb_keep30", rd[0], 32'h3030_3030);
        run(1, 32'h34, 1'b0, 4'hF, 3'b000, 2'b00, 0);
        chk("rstb_keep34", rd[0], 32'h3434_3434);

        // Three wait states: linear 8-beat write then classic reads
        use3 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wd[i]   = 32'h1000_0000 + 32'h111 * 32'(i);
            keep[i] = wd[i];
        end
        run(8, 32'h100, 1'b1, 4'hF, 3'b010, 2'b00, 0);
        chk("ws3_nack", nack, 8);
        chk("ws3_first", ackedge[0], 4);
        chk("ws3_last", ackedge[7], 11);
        chk("ws3_drop", post_a1, 0);
        for (int i = 0; i < 8; i++) begin
            run(1, 32'h100 + 32'(4 * i), 1'b0, 4'hF, 3'b000, 2'b00, 0);
            chk($sformatf("ws3_rd%0d", i), rd[0], keep[i]);
            chk($sformatf("ws3_lat%0d", i), ackedge[0], 4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
